time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 142 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller for an HH:MM:SS clock: freezes the counters and edits
// shadow copies of the fields, then loads them back. Optional blink via SET_BLINK_EN.
module time_set_ctrl #(
    parameter int WIDTH     = 8,
    parameter int HR_LIMIT  = 23,
    parameter int MIN_LIMIT = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             mode_btn,
    input  logic             inc_btn,
    input  logic [WIDTH-1:0] q_hr,
    input  logic [WIDTH-1:0] q_min,
    input  logic [WIDTH-1:0] q_sec,
    output logic             count_en,
    output logic             load_en,
    output logic [WIDTH-1:0] ld_hr,
    output logic [WIDTH-1:0] ld_min,
    output logic [WIDTH-1:0] ld_sec,
    output logic [1:0]       sel,
    output logic             blink
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        LOAD    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] HR_MAX  = WIDTH'(HR_LIMIT);
    localparam logic [WIDTH-1:0] MIN_MAX = WIDTH'(MIN_LIMIT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_hr_q, sh_hr_d;
    logic [WIDTH-1:0] sh_min_q, sh_min_d;
    logic [WIDTH-1:0] sh_sec_q, sh_sec_d;
    logic             in_set;

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] lim);
        return (v == lim) ? '0 : v + ONE;
    endfunction

    assign in_set = (state_q == SET_HR) || (state_q == SET_MIN) || (state_q == SET_SEC);

    // mode_btn is tested before inc_btn in every SET state, so a simultaneous
    // inc_btn is dropped rather than applied to the field being left.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d  = state_q;
        sh_hr_d  = sh_hr_q;
        sh_min_d = sh_min_q;
        sh_sec_d = sh_sec_q;
        unique case (state_q)
            RUN: begin
                if (mode_btn) begin
                    state_d  = SET_HR;
                    sh_hr_d  = q_hr;
                    sh_min_d = q_min;
                    sh_sec_d = q_sec;
                end
            end
            SET_HR: begin
                if (mode_btn)     state_d = SET_MIN;
                else if (inc_btn) sh_hr_d = wrap_inc(sh_hr_q, HR_MAX);
            end
            SET_MIN: begin
                if (mode_btn)     state_d  = SET_SEC;
                else if (inc_btn) sh_min_d = wrap_inc(sh_min_q, MIN_MAX);
            end
            SET_SEC: begin
                if (mode_btn)     state_d  = LOAD;
                else if (inc_btn) sh_sec_d = wrap_inc(sh_sec_q, MIN_MAX);
            end
            LOAD:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q  <= RUN;
            sh_hr_q  <= '0;
            sh_min_q <= '0;
            sh_sec_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_hr_q  <= sh_hr_d;
            sh_min_q <= sh_min_d;
            sh_sec_q <= sh_sec_d;
        end
    end

`ifdef SET_BLINK_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (state_q == RUN || (state_d == SET_HR && state_q != SET_HR)) phase_d = 1'b0;
        else if (in_set && tick)                                     phase_d = ~phase_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) phase_q <= 1'b0;
        else        phase_q <= phase_d;
    end

    assign blink = rst_n && in_set && phase_q;
`else
    assign blink = 1'b0;
`endif

    // Reset is synchronous, so outputs are gated by rst_n to stay quiet
    // before the first reset edge has cleaned up the registers.
    always_comb begin
        count_en = 1'b0;
        load_en  = 1'b0;
        ld_hr    = '0;
        ld_min   = '0;
        ld_sec   = '0;
        sel      = 2'd0;
        if (rst_n) begin
            count_en = tick && (state_q == RUN);
            load_en  = (state_q == LOAD);
            ld_hr    = sh_hr_q;
            ld_min   = sh_min_q;
            ld_sec   = sh_sec_q;
            unique case (state_q)
                SET_HR:  sel = 2'd1;
                SET_MIN: sel = 2'd2;
                SET_SEC: sel = 2'd3;
                default: sel = 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected load values are queued as each
// set sequence is driven and checked when load_en appears.
module tb_time_set_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic         mode_btn = 1'b0;
    logic         inc_btn = 1'b0;
    logic [W-1:0] q_hr = '0, q_min = '0, q_sec = '0;
    logic         count_en, load_en, blink;
    logic [W-1:0] ld_hr, ld_min, ld_sec;
    logic [1:0]   sel;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;
    logic [3*W-1:0] sb_q[$];

    time_set_ctrl #(.WIDTH(W), .HR_LIMIT(23), .MIN_LIMIT(59)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .q_hr(q_hr), .q_min(q_min), .q_sec(q_sec),
        .count_en(count_en), .load_en(load_en),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .sel(sel), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (load_en === 1'b1) begin
            n_loads++;
            if (sb_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
            else                  check("load_value", {8'd0, ld_hr, ld_min, ld_sec}, {8'd0, sb_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; cyc(); mode_btn = 1'b0;
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; cyc(); inc_btn = 1'b0;
    endtask

    task automatic do_tick(output logic ce);
        tick = 1'b1; #1; ce = count_en; cyc(); tick = 1'b0;
    endtask

    task automatic set_q(input int h, input int m, input int s);
        q_hr = W'(h); q_min = W'(m); q_sec = W'(s);
    endtask

    logic ce;

    initial begin
        // Reset held with tick high: everything must stay quiet.
        tick = 1'b1;
        #1;
        check("rst_count_en_pre", count_en, 0);
        cyc(); cyc();
        check("rst_count_en", count_en, 0);
        check("rst_load_en", load_en, 0);
        check("rst_sel", sel, 0);
        check("rst_ld_hr", ld_hr, 0);
        check("rst_blink", blink, 0);
        tick = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            do_tick(ce);
            check("run_count_en", ce, 1);
            check("run_load_en", load_en, 0);
            check("run_sel", sel, 0);
        end

        // 12:34:56 -> 14:35:56
        set_q(12, 34, 56);
        press_mode();
        check("set_hr_sel", sel, 1);
        check("set_hr_capture", ld_hr, 12);
        press_inc(); press_inc();
        check("set_hr_inc2", ld_hr, 14);
        do_tick(ce);
        check("set_hr_frozen", ce, 0);
        press_mode();
        check("set_min_sel", sel, 2);
        press_inc();
        check("set_min_inc", ld_min, 35);
        press_mode();
        check("set_sec_sel", sel, 3);
        sb_q.push_back({8'd14, 8'd35, 8'd56});
        press_mode();
        check("load_en_on", load_en, 1);
        check("load_sel", sel, 0);
        tick = 1'b1; inc_btn = 1'b1;
        #1;
        check("load_tick_lost", count_en, 0);
        cyc();
        tick = 1'b0; inc_btn = 1'b0;
        check("post_load_en", load_en, 0);
        check("post_load_sel", sel, 0);
        check("load_inc_ignored", ld_hr, 14);
        press_inc();
        check("run_inc_ignored", ld_hr, 14);

        // Wrap of every field at its limit.
        set_q(23, 59, 59);
        press_mode();
        press_inc();
        check("hr_wrap", ld_hr, 0);
        press_mode();
        press_inc();
        check("min_wrap", ld_min, 0);
        press_mode();
        press_inc();
        check("sec_wrap", ld_sec, 0);
        sb_q.push_back({8'd0, 8'd0, 8'd0});
        press_mode();
        cyc();

        // mode and inc together: mode wins, inc dropped.
        set_q(5, 6, 7);
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1;
        cyc();
        mode_btn = 1'b0; inc_btn = 1'b0;
        check("both_sel", sel, 2);
        check("both_hr_kept", ld_hr, 5);
        press_mode();
        sb_q.push_back({8'd5, 8'd6, 8'd7});
        press_mode();
        cyc();

        // Blink over four ticks in SET_HR.
        set_q(1, 2, 3);
        press_mode();
        check("blink_entry", blink, 0);
        for (int i = 0; i < 4; i++) begin
            do_tick(ce);
            check("blink_count_en", ce, 0);
`ifdef SET_BLINK_EN
            check("blink_phase", blink, (i % 2 == 0) ? 1 : 0);
`else
            check("blink_phase", blink, 0);
`endif
        end

        // Abort from SET_MIN after an edit.
        press_mode();
        press_inc();
        check("abort_pre_min", ld_min, 3);
        rst_n = 1'b0;
        #1;
        check("abort_sel_in_rst", sel, 0);
        check("abort_load_in_rst", load_en, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("abort_sel", sel, 0);
        check("abort_sh_hr", ld_hr, 0);
        check("abort_sh_min", ld_min, 0);
        check("abort_sh_sec", ld_sec, 0);
        check("abort_blink", blink, 0);
        do_tick(ce);
        check("abort_tick_resumes", ce, 1);

        repeat (3) cyc();
        check("sb_drain", sb_q.size(), 0);
        check("load_count", n_loads, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
